// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
//   Round-robin bus arbiter for CHANNEL_NUM requesters. An owner keeps the
//   bus until a transfer completes (hready high) that is either flagged as
//   the last of its burst or no longer requested. On release the next winner
//   is granted at the same edge, scanning from the channel after the owner.
//
// Ports
//   HCLK       in   clock, all state changes on the rising edge
//   HRESETn    in   asynchronous active-low reset
//   req        in   [CHANNEL_NUM]  per-channel request (level)
//   xfer_last  in   [CHANNEL_NUM]  per-channel last-transfer-of-burst flag
//   hready     in   transfer-complete qualifier
//   sel        out  [CHANNEL_NUM]  registered one-hot grant, zero = no owner
//   grant_idx  out  [IDX_W]        binary index of the granted channel
//   busy       out  high while a channel owns the bus
module ahb_rr_arbiter #(
  parameter int CHANNEL_NUM = 7,
  localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [CHANNEL_NUM-1:0] req,
  input  logic [CHANNEL_NUM-1:0] xfer_last,
  input  logic                   hready,
  output logic [CHANNEL_NUM-1:0] sel,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]             state;
  logic [IDX_W-1:0]       ptr;
  logic                   release_now;
  logic [IDX_W-1:0]       next_ptr;
  logic [IDX_W-1:0]       scan_base;
  logic                   found;
  logic [IDX_W-1:0]       win_idx;
  logic [CHANNEL_NUM-1:0] win_onehot;
  int                     cand;
  logic [IDX_W-1:0]       cand_idx;

  // The owner lets go only on a completed transfer that ends its burst or
  // that it no longer wants.
  assign release_now = (state == OWNED) && hready &&
                       (xfer_last[grant_idx] || !req[grant_idx]);

  // Pointer after a release: one past the owner, wrapping to channel 0.
  assign next_ptr = (grant_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0
                                                          : grant_idx + IDX_W'(1);

  // On release the scan starts from the updated pointer so the releasing
  // owner is considered last.
  assign scan_base = release_now ? next_ptr : ptr;

  always_comb begin
    found      = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      cand = int'(scan_base) + i;
      if (cand >= CHANNEL_NUM) cand = cand - CHANNEL_NUM;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
    win_onehot[win_idx] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      grant_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state     <= OWNED;
            sel       <= win_onehot;
            grant_idx <= win_idx;
          end
        end
        OWNED: begin
          if (release_now) begin
            ptr <= next_ptr;
            if (found) begin
              sel       <= win_onehot;
              grant_idx <= win_idx;
            end else begin
              // grant_idx keeps the last owner while idle
              state <= IDLE;
              sel   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == OWNED);

endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNEL_NUM, default 7, giving the number of requesting channels (range 1..16).
REQ-002 The block SHALL have port HCLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port HRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, CHANNEL_NUM bits: per-channel bus request, level-sensitive.
REQ-005 The block SHALL have port xfer_last, input, CHANNEL_NUM bits: per-channel flag marking the current transfer as the last of the owner's burst.
REQ-006 The block SHALL have port hready, input, 1 bit: bus transfer-complete qualifier.
REQ-007 The block SHALL have port sel, output, CHANNEL_NUM bits: registered one-hot grant that drives the downstream payload mux select; all-zero means no owner.
REQ-008 The block SHALL have port grant_idx, output, $clog2(CHANNEL_NUM) bits (minimum 1): binary index of the granted channel.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a channel owns the bus.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and OWNED (one owner).
REQ-011 sel SHALL always be one-hot or all-zero; sel is all-zero only in IDLE.
REQ-012 grant_idx SHALL equal the bit position of sel when in OWNED, and SHALL hold its last value in IDLE.
REQ-013 busy SHALL be high exactly when the FSM is in OWNED.
REQ-014 The block SHALL keep a round-robin pointer ptr, 0..CHANNEL_NUM-1; the winner is the first asserted req scanning ptr, ptr+1, ... with modulo-CHANNEL_NUM wrap.
REQ-015 In IDLE with any req bit high, the block SHALL register the winner into sel and grant_idx and move to OWNED at the next edge (1-cycle grant latency).
REQ-016 In IDLE with req all-zero, the block SHALL stay in IDLE with sel all-zero.
REQ-017 In OWNED, the grant SHALL be held unchanged in every cycle where hready is low, regardless of req and xfer_last.
REQ-018 In OWNED, release SHALL occur at an edge where hready is high and either xfer_last[owner] or NOT req[owner] is true.
REQ-019 On release, ptr SHALL become (owner+1) mod CHANNEL_NUM, wrapping CHANNEL_NUM-1 to 0.
REQ-020 On release, if any req bit is high in the same cycle, the block SHALL grant the winner from the updated ptr at that same edge with no idle cycle; the releasing owner is lowest priority.
REQ-021 On release with req all-zero, the block SHALL enter IDLE with sel all-zero.
REQ-022 A new request arriving while another channel owns the bus SHALL NOT preempt the owner.
REQ-023 With CHANNEL_NUM=1, ptr SHALL stay 0 and channel 0 SHALL be re-granted back-to-back while req[0] stays high.

Reset
REQ-024 While HRESETn is low, the outputs SHALL be sel=0, grant_idx=0, busy=0, with FSM in IDLE and ptr=0.
REQ-025 Reset assertion mid-burst SHALL clear the grant immediately, without waiting for HCLK.
REQ-026 After HRESETn deasserts, the first grant SHALL follow REQ-015 with channel 0 highest priority.

Verification
REQ-027 Scenario: after reset, req=7'b0000100, hready=1 -> next edge sel=7'b0000100, grant_idx=2, busy=1.
REQ-028 Scenario: req=7'b1111111 constant, each owner asserts xfer_last with hready=1 once per grant -> grants rotate 0,1,2,...,6,0 back-to-back, with no idle cycle.
REQ-029 Scenario: owner=3, xfer_last[3]=1, hready=0 for 4 cycles, then 1 -> sel holds 7'b0001000 for 4 cycles and releases at the hready edge.
REQ-030 Scenario: owner=6 releases while req=7'b1000001 -> ptr wraps to 0 and channel 0 is granted next.
REQ-031 Scenario: owner=1, req[5] rises mid-burst -> sel stays 7'b0000010 until channel 1 releases, then sel=7'b0100000.
REQ-032 Scenario: HRESETn pulsed low between edges while busy=1 -> sel=0 and busy=0 take effect asynchronously, and ptr=0 afterwards.
